pifo_tree_driver: RTL and testbench

Root-side command initiator for the 4-ary PIFO tree: accepts enqueue and dequeue requests from the scheduler through valid/ready handshakes and serialises them into single-cycle push/pop commands on the tree root node's parent port. It tracks occupancy, blocks pushes when full and pops when empty, enforces the minimum inter-command gap the tree pipeline needs, and returns popped entries with a valid strobe. It sits between the scheduler/traffic manager and the root PIFO node.

---
 rtl/pifo_tree_driver.sv | 143 ++++++++++++++
 tb/tb_pifo_tree_driver.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pifo_tree_driver.sv
// Root-side command initiator for the 4-ary PIFO tree: serialises enqueue/dequeue handshakes
// into gapped push/pop commands. Optional statistics outputs enabled by PIFO_DRV_STATS_EN.
module pifo_tree_driver #(
   parameter int PTW  = 16,
   parameter int MTW  = 32,
   parameter int CAP  = 1020,
   parameter int GAP  = 2,
   parameter int CNTW = $clog2(CAP + 1)
) (
   input  logic                 i_clk,
   input  logic                 i_arst_n,
   input  logic                 i_enq_valid,
   input  logic [MTW+PTW-1:0]   i_enq_data,
   output logic                 o_enq_ready,
   input  logic                 i_deq_req,
   output logic                 o_deq_ready,
   output logic                 o_deq_valid,
   output logic [MTW+PTW-1:0]   o_deq_data,
   output logic                 o_push,
   output logic [MTW+PTW-1:0]   o_push_data,
   output logic                 o_pop,
   input  logic [MTW+PTW-1:0]   i_pop_data,
   output logic [CNTW-1:0]      o_count,
   output logic                 o_full,
   output logic                 o_empty,
   output logic                 o_drop,
   output logic                 o_err
`ifdef PIFO_DRV_STATS_EN
   ,
   output logic [31:0]          o_stat_enq,
   output logic [31:0]          o_stat_deq,
   output logic [31:0]          o_stat_drop
`endif
);

   localparam int DW = MTW + PTW;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic {IDLE, HOLD} state_t;

   state_t           state_q, state_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic [CNTW-1:0]  count_q, count_d;
   logic             rr_q;
   logic             push_q, pop_q, drop_q, deq_valid_q, err_q;
   logic [DW-1:0]    push_data_q, deq_data_q;

   logic idle, enq_elig, deq_elig, enq_gnt, deq_gnt, enq_drop, enq_push;

   assign o_full   = (count_q == CNTW'(CAP));
   assign o_empty  = (count_q == '0);
   assign idle     = (state_q == IDLE);
   assign enq_elig = idle && i_enq_valid && !o_full;
   assign deq_elig = idle && i_deq_req && !o_empty;

   // rr_q == 0 favours dequeue when both sides contend
   assign o_enq_ready = idle && !o_full && !(deq_elig && !rr_q);
   assign o_deq_ready = idle && !o_empty && !(enq_elig && rr_q);
   assign enq_gnt     = i_enq_valid && o_enq_ready;
   assign deq_gnt     = i_deq_req && o_deq_ready;
   assign enq_drop    = enq_gnt && (&i_enq_data[PTW-1:0]);
   assign enq_push    = enq_gnt && !enq_drop;

   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if ((enq_gnt || deq_gnt) && (GAP > 1)) begin
               state_d = HOLD;
               gap_d   = GW'(GAP - 1);
            end
         end
         HOLD: begin
            gap_d = gap_q - GW'(1);
            if (gap_q == GW'(1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (enq_push)     count_d = count_q + CNTW'(1);
      else if (deq_gnt) count_d = count_q - CNTW'(1);
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q     <= IDLE;
         gap_q       <= '0;
         count_q     <= '0;
         rr_q        <= 1'b0;
         push_q      <= 1'b0;
         push_data_q <= '0;
         pop_q       <= 1'b0;
         drop_q      <= 1'b0;
         deq_valid_q <= 1'b0;
         deq_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         gap_q       <= gap_d;
         count_q     <= count_d;
         if (enq_elig && deq_elig) rr_q <= !rr_q;
         push_q      <= enq_push;
         push_data_q <= enq_push ? i_enq_data : '0;
         pop_q       <= deq_gnt;
         drop_q      <= enq_drop;
         deq_valid_q <= pop_q;
         if (pop_q) deq_data_q <= i_pop_data;
         // a pop is only ever issued with a nonzero count, so an empty marker here is a tree fault
         if (pop_q && (&i_pop_data[PTW-1:0])) err_q <= 1'b1;
      end
   end

   assign o_count     = count_q;
   assign o_push      = push_q;
   assign o_push_data = push_data_q;
   assign o_pop       = pop_q;
   assign o_drop      = drop_q;
   assign o_deq_valid = deq_valid_q;
   assign o_deq_data  = deq_data_q;
   assign o_err       = err_q;

`ifdef PIFO_DRV_STATS_EN
   logic [31:0] stat_enq_q, stat_deq_q, stat_drop_q;

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         stat_enq_q  <= '0;
         stat_deq_q  <= '0;
         stat_drop_q <= '0;
      end else begin
         if (push_q && !(&stat_enq_q))  stat_enq_q  <= stat_enq_q + 32'd1;
         if (pop_q && !(&stat_deq_q))   stat_deq_q  <= stat_deq_q + 32'd1;
         if (drop_q && !(&stat_drop_q)) stat_drop_q <= stat_drop_q + 32'd1;
      end
   end

   assign o_stat_enq  = stat_enq_q;
   assign o_stat_deq  = stat_deq_q;
   assign o_stat_drop = stat_drop_q;
`endif

endmodule

// File: tb/tb_pifo_tree_driver.sv
// Bench for pifo_tree_driver: models the root PIFO and the driver's handshake/command rules,
// comparing every cycle, plus directed literal checks.
module tb_pifo_tree_driver;

   localparam int PTW  = 16;
   localparam int MTW  = 32;
   localparam int CAP  = 1020;
   localparam int GAP  = 2;
   localparam int CNTW = $clog2(CAP + 1);
   localparam int DW   = MTW + PTW;

   logic            clk;
   logic            i_arst_n;
   logic            i_enq_valid;
   logic [DW-1:0]   i_enq_data;
   logic            o_enq_ready;
   logic            i_deq_req;
   logic            o_deq_ready;
   logic            o_deq_valid;
   logic [DW-1:0]   o_deq_data;
   logic            o_push;
   logic [DW-1:0]   o_push_data;
   logic            o_pop;
   logic [DW-1:0]   i_pop_data;
   logic [CNTW-1:0] o_count;
   logic            o_full, o_empty, o_drop, o_err;

   pifo_tree_driver #(.PTW(PTW), .MTW(MTW), .CAP(CAP), .GAP(GAP), .CNTW(CNTW)) dut (
      .i_clk(clk), .i_arst_n(i_arst_n),
      .i_enq_valid(i_enq_valid), .i_enq_data(i_enq_data), .o_enq_ready(o_enq_ready),
      .i_deq_req(i_deq_req), .o_deq_ready(o_deq_ready),
      .o_deq_valid(o_deq_valid), .o_deq_data(o_deq_data),
      .o_push(o_push), .o_push_data(o_push_data), .o_pop(o_pop), .i_pop_data(i_pop_data),
      .o_count(o_count), .o_full(o_full), .o_empty(o_empty), .o_drop(o_drop), .o_err(o_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      else pass_cnt++;
   endtask

   // lowest priority wins; ties go to the oldest entry
   function automatic int min_idx(input logic [DW-1:0] q[$]);
      int best;
      best = -1;
      for (int i = 0; i < q.size(); i++)
         if (best < 0 || q[i][PTW-1:0] < q[best][PTW-1:0]) best = i;
      return best;
   endfunction

   // reference model state
   logic [DW-1:0] ref_q[$];
   int            m_cnt = 0;
   int            m_gap = 0;
   bit            m_rr = 0;
   bit            e_push = 0, e_pop = 0, e_drop = 0, e_dv = 0, m_dv = 0;
   logic [DW-1:0] e_push_data = '0, e_dd = '0, m_dd = '0;
   // tree model state
   logic [DW-1:0] tree_q[$];
   bit            t_push_pend = 0, t_pop_pend = 0;
   logic [DW-1:0] t_push_data = '0;
   // logs for directed checks
   logic [DW-1:0] dq_log[$];
   byte           gnt_log[$];
   int            gnt_cyc[$];
   int            cyc = 0, dv_seen = 0, drop_seen = 0;

   initial i_pop_data = '1;

   always @(negedge clk) begin
      bit idle, enq_el, deq_el, g_enq, g_deq;
      int k;
      cyc++;
      if (!i_arst_n) begin
         chk("rst_push", o_push, 0);
         chk("rst_pop", o_pop, 0);
         chk("rst_push_data", o_push_data, 0);
         chk("rst_deq_valid", o_deq_valid, 0);
         chk("rst_deq_data", o_deq_data, 0);
         chk("rst_count", o_count, 0);
         chk("rst_flags", {o_empty, o_full, o_drop, o_err}, 4'b1000);
         ref_q.delete(); tree_q.delete();
         m_cnt = 0; m_gap = 0; m_rr = 0;
         e_push = 0; e_pop = 0; e_drop = 0; e_dv = 0; m_dv = 0;
         e_push_data = '0; e_dd = '0; m_dd = '0;
         t_push_pend = 0; t_pop_pend = 0;
         i_pop_data = '1;
      end else begin
         chk("push", o_push, e_push);
         chk("push_data", o_push_data, e_push_data);
         chk("pop", o_pop, e_pop);
         chk("drop", o_drop, e_drop);
         chk("deq_valid", o_deq_valid, e_dv);
         if (e_dv) chk("deq_data", o_deq_data, e_dd);
         chk("count", o_count, m_cnt);
         chk("full", o_full, m_cnt == CAP);
         chk("empty", o_empty, m_cnt == 0);
         chk("err", o_err, 0);
         chk("push_pop_excl", o_push & o_pop, 0);

         idle   = (m_gap == 0);
         enq_el = idle && i_enq_valid && (m_cnt < CAP);
         deq_el = idle && i_deq_req && (m_cnt > 0);
         g_deq  = deq_el && (!enq_el || !m_rr);
         g_enq  = enq_el && !g_deq;
         chk("enq_hs", i_enq_valid && o_enq_ready, g_enq);
         chk("deq_hs", i_deq_req && o_deq_ready, g_deq);
         if (!idle) chk("hold_ready", {o_enq_ready, o_deq_ready}, 2'b00);

         if (o_deq_valid) begin dq_log.push_back(o_deq_data); dv_seen++; end
         if (o_drop) drop_seen++;

         e_dv = m_dv; e_dd = m_dd; m_dv = 0;
         e_push = 0; e_push_data = '0; e_pop = 0; e_drop = 0;
         if (enq_el && deq_el) m_rr = !m_rr;
         if (g_enq || g_deq) m_gap = GAP - 1;
         else if (m_gap > 0) m_gap--;
         if (g_enq) begin
            gnt_log.push_back("E"); gnt_cyc.push_back(cyc);
            if (&i_enq_data[PTW-1:0]) e_drop = 1;
            else begin
               e_push = 1; e_push_data = i_enq_data;
               ref_q.push_back(i_enq_data); m_cnt++;
            end
         end
         if (g_deq) begin
            gnt_log.push_back("D"); gnt_cyc.push_back(cyc);
            k = min_idx(ref_q);
            m_dd = ref_q[k]; ref_q.delete(k);
            m_dv = 1; e_pop = 1; m_cnt--;
         end

         // tree root: commands from the previous cycle take effect now
         if (t_push_pend) tree_q.push_back(t_push_data);
         if (t_pop_pend && tree_q.size() > 0) tree_q.delete(min_idx(tree_q));
         t_push_pend = o_push; t_push_data = o_push_data; t_pop_pend = o_pop;
         k = min_idx(tree_q);
         i_pop_data = (k < 0) ? '1 : tree_q[k];
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_enq(input logic [DW-1:0] d);
      int k;
      i_enq_valid = 1'b1; i_enq_data = d; #1;
      k = 0;
      while (!o_enq_ready && k < 100) begin @(posedge clk); #2; k++; end
      if (k >= 100) chk("enq_timeout", 1, 0);
      @(posedge clk); #1;
      i_enq_valid = 1'b0; i_enq_data = '0;
   endtask

   task automatic do_deq();
      int k;
      i_deq_req = 1'b1; #1;
      k = 0;
      while (!o_deq_ready && k < 100) begin @(posedge clk); #2; k++; end
      if (k >= 100) chk("deq_timeout", 1, 0);
      @(posedge clk); #1;
      i_deq_req = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (o_count != 0 && k < 3000) begin do_deq(); k++; end
      step(3);
      chk("drained", o_count, 0);
   endtask

   initial begin
      int k, dv_before;
      bit found;
      i_arst_n = 1'b0; i_enq_valid = 1'b0; i_enq_data = '0; i_deq_req = 1'b0;
      step(3);
      i_arst_n = 1'b1;
      step(1);
      chk("init_empty", o_empty, 1);
      chk("init_count", o_count, 0);
      chk("init_ready", {o_enq_ready, o_deq_ready}, 2'b10);

      // single enqueue
      do_enq({32'hA, 16'd5});
      chk("lit_push", o_push, 1);
      chk("lit_push_data", o_push_data, {32'hA, 16'd5});
      chk("lit_count1", o_count, 1);
      chk("lit_not_empty", o_empty, 0);
      step(1);
      chk("lit_push_once", o_push, 0);

      // priority ordering and latency
      do_enq({32'd1, 16'd9});
      do_enq({32'd2, 16'd3});
      do_enq({32'd3, 16'd7});
      dq_log.delete();
      do_deq();
      chk("lit_pop_cycle", o_pop, 1);
      step(1);
      chk("lit_dv_lat", o_deq_valid, 1);
      chk("lit_dv_pri", o_deq_data[PTW-1:0], 3);
      do_deq(); do_deq(); do_deq();
      step(3);
      chk("lit_order_n", dq_log.size(), 4);
      if (dq_log.size() == 4)
         chk("lit_order", {dq_log[0][15:0], dq_log[1][15:0], dq_log[2][15:0], dq_log[3][15:0]},
             {16'd3, 16'd5, 16'd7, 16'd9});
      chk("lit_count0", o_count, 0);

      // contention: both requests held
      do_enq({32'd4, 16'd20});
      do_enq({32'd5, 16'd21});
      gnt_log.delete(); gnt_cyc.delete();
      i_enq_valid = 1'b1; i_enq_data = {32'd6, 16'd100}; i_deq_req = 1'b1;
      step(20);
      i_enq_valid = 1'b0; i_deq_req = 1'b0;
      chk("lit_rr_n", gnt_log.size() >= 4, 1);
      if (gnt_log.size() >= 4) begin
         chk("lit_rr_order", {gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]}, "DEDE");
         chk("lit_gap1", gnt_cyc[1] - gnt_cyc[0], GAP);
         chk("lit_gap2", gnt_cyc[3] - gnt_cyc[2], GAP);
      end
      drain();

      // dequeue from empty
      i_deq_req = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("lit_empty_deq_ready", o_deq_ready, 0);
         step(1);
      end
      i_deq_req = 1'b0;

      // drop of an all-ones priority
      do_enq({32'd7, 16'd40});
      step(2);
      k = drop_seen;
      do_enq({32'hBEEF, 16'hFFFF});
      chk("lit_drop", o_drop, 1);
      chk("lit_drop_nopush", o_push, 0);
      chk("lit_drop_count", o_count, 1);
      step(1);
      chk("lit_drop_once", drop_seen - k, 1);
      drain();

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         i_enq_valid = ($urandom_range(0, 1) == 1);
         i_enq_data  = {$urandom(), ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 300))};
         i_deq_req   = ($urandom_range(0, 1) == 1);
         step(1);
      end
      i_enq_valid = 1'b0; i_deq_req = 1'b0;
      step(2);

      // fill to capacity
      i_enq_valid = 1'b1;
      k = 0;
      while (!o_full && k < 5000) begin
         i_enq_data = {$urandom(), 16'($urandom_range(0, 16'hFFFE))};
         step(1);
         k++;
      end
      if (k >= 5000) chk("fill_timeout", 1, 0);
      #1;
      chk("lit_full", o_full, 1);
      chk("lit_full_count", o_count, CAP);
      chk("lit_full_ready", o_enq_ready, 0);
      step(4);
      chk("lit_full_ready2", o_enq_ready, 0);
      i_enq_valid = 1'b0;
      step(2);

      // reset during a pop cycle
      i_deq_req = 1'b1;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(posedge clk); #1;
         if (o_pop) found = 1;
      end
      if (!found) chk("pop_timeout", 1, 0);
      dv_before = dv_seen;
      i_arst_n = 1'b0; i_deq_req = 1'b0;
      #1;
      chk("lit_rst_pop", o_pop, 0);
      chk("lit_rst_count", o_count, 0);
      chk("lit_rst_empty", o_empty, 1);
      chk("lit_rst_dv", o_deq_valid, 0);
      step(2);
      i_arst_n = 1'b1;
      step(5);
      chk("lit_no_dv_after_rst", dv_seen, dv_before);
      chk("lit_post_rst_ready", {o_enq_ready, o_deq_ready}, 2'b10);
      step(2);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
